// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and helpers for the elastic register pipeline.
//   pipe_mode_e : stage flavour (combinational ready chain or skid buffer)
//   occ_width() : bit width needed to count every entry the pipeline can hold
package pipe_pkg;

    typedef enum logic {
        PIPE_COMB_READY = 1'b0,
        PIPE_SKID       = 1'b1
    } pipe_mode_e;

    // A skid stage holds two entries, a plain stage one.
    function automatic int occ_width(input int depth, input int mode);
        return $clog2(depth * (1 + mode) + 1);
    endfunction

endpackage

// File: rtl/pipe_reg_slice_stage.sv
// pipe_stage: one elastic register stage with valid/ready on both sides.
//   clk, rst_n          : clock, asynchronous active-low reset (valids only,
//                         data too when RESET_DATA=1)
//   flush_i             : synchronous clear of the held entries
//   up_valid/up_ready/up_data : upstream handshake
//   dn_valid/dn_ready/dn_data : downstream handshake
// SKID_MODE=0: single register, ready passes through combinationally.
// SKID_MODE=1: main + skid entry, up_ready comes straight from a flop.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    SKID_MODE  = 0,
    parameter bit                    RESET_DATA = 1'b1,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  up_valid,
    output logic                  up_ready,
    input  logic [DATA_WIDTH-1:0] up_data,
    output logic                  dn_valid,
    input  logic                  dn_ready,
    output logic [DATA_WIDTH-1:0] dn_data
);

    localparam pipe_mode_e MODE = (SKID_MODE != 0) ? PIPE_SKID : PIPE_COMB_READY;

    if (MODE == PIPE_COMB_READY) begin : g_comb
        logic                  vld_q, vld_d;
        logic [DATA_WIDTH-1:0] data_q, data_d;

        assign up_ready = !vld_q || dn_ready;

        always_comb begin
            vld_d  = vld_q;
            data_d = data_q;
            if (flush_i) begin
                vld_d = 1'b0;
            end else if (up_ready) begin
                vld_d = up_valid;
                // Data only loads with a real word so idle cycles leave it quiet.
                if (up_valid) data_d = up_data;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) vld_q <= 1'b0;
            else        vld_q <= vld_d;
        end

        if (RESET_DATA) begin : g_rst_data
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) data_q <= RST_VAL;
                else        data_q <= data_d;
            end
        end else begin : g_free_data
            always_ff @(posedge clk) data_q <= data_d;
        end

        assign dn_valid = vld_q;
        assign dn_data  = data_q;
    end else begin : g_skid
        logic                  main_vld_q, main_vld_d;
        logic                  skid_vld_q, skid_vld_d;
        logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
        logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
        logic                  pop, push;

        // Registered ready: accept only while the skid slot is free.
        assign up_ready = !skid_vld_q;

        always_comb begin
            pop         = main_vld_q && dn_ready;
            push        = up_valid && !skid_vld_q;
            main_vld_d  = main_vld_q;
            skid_vld_d  = skid_vld_q;
            main_data_d = main_data_q;
            skid_data_d = skid_data_q;
            if (flush_i) begin
                main_vld_d = 1'b0;
                skid_vld_d = 1'b0;
            end else if (skid_vld_q) begin
                // Skid refills main first; no push is possible while it is full.
                if (pop) begin
                    main_vld_d  = 1'b1;
                    main_data_d = skid_data_q;
                    skid_vld_d  = 1'b0;
                end
            end else if (push) begin
                if (!main_vld_q || pop) begin
                    main_vld_d  = 1'b1;
                    main_data_d = up_data;
                end else begin
                    skid_vld_d  = 1'b1;
                    skid_data_d = up_data;
                end
            end else if (pop) begin
                main_vld_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                main_vld_q <= 1'b0;
                skid_vld_q <= 1'b0;
            end else begin
                main_vld_q <= main_vld_d;
                skid_vld_q <= skid_vld_d;
            end
        end

        if (RESET_DATA) begin : g_rst_data
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_data_q <= RST_VAL;
                    skid_data_q <= RST_VAL;
                end else begin
                    main_data_q <= main_data_d;
                    skid_data_q <= skid_data_d;
                end
            end
        end else begin : g_free_data
            always_ff @(posedge clk) begin
                main_data_q <= main_data_d;
                skid_data_q <= skid_data_d;
            end
        end

        assign dn_valid = main_vld_q;
        assign dn_data  = main_data_q;
    end

endmodule

// File: rtl/pipe_reg_slice.sv
// pipe_reg_slice: DEPTH-stage elastic register pipeline with valid/ready on
// both ends, synchronous flush and an entry counter.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   flush_i                     : drop every held entry at the next edge
//   in_valid/in_ready/in_data   : upstream handshake
//   out_valid/out_ready/out_data: downstream handshake
//   occupancy                   : number of entries currently held
module pipe_reg_slice
    import pipe_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    DEPTH      = 4,
    parameter int                    SKID_MODE  = 0,
    parameter bit                    RESET_DATA = 1'b1,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0,
    localparam int                   CNT_W      = occ_width(DEPTH, SKID_MODE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]      occupancy
);

    // Each stage keeps its own boundary nets so the ready chain stays a set
    // of distinct signals rather than one self-referencing vector.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic                  up_valid, up_ready, dn_valid, dn_ready;
        logic [DATA_WIDTH-1:0] up_data, dn_data;

        if (i == 0) begin : g_head
            assign up_valid = in_valid && !flush_i;
            assign up_data  = in_data;
        end else begin : g_link
            assign up_valid = g_stage[i-1].dn_valid;
            assign up_data  = g_stage[i-1].dn_data;
        end

        if (i == DEPTH - 1) begin : g_tail
            assign dn_ready = out_ready && !flush_i;
        end else begin : g_fwd
            assign dn_ready = g_stage[i+1].up_ready;
        end

        pipe_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .SKID_MODE  (SKID_MODE),
            .RESET_DATA (RESET_DATA),
            .RST_VAL    (RST_VAL)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush_i  (flush_i),
            .up_valid (up_valid),
            .up_ready (up_ready),
            .up_data  (up_data),
            .dn_valid (dn_valid),
            .dn_ready (dn_ready),
            .dn_data  (dn_data)
        );
    end

    // Flush blocks both handshakes in its own cycle.
    assign in_ready  = g_stage[0].up_ready && !flush_i;
    assign out_valid = g_stage[DEPTH-1].dn_valid && !flush_i;
    assign out_data  = g_stage[DEPTH-1].dn_data;

    logic             in_xfer, out_xfer;
    logic [CNT_W-1:0] occ_q, occ_d;

    always_comb begin
        in_xfer  = in_valid && in_ready;
        out_xfer = out_valid && out_ready;
        occ_d    = occ_q;
        if (flush_i) begin
            occ_d = '0;
        end else if (in_xfer && !out_xfer) begin
            occ_d = occ_q + CNT_W'(1);
        end else if (!in_xfer && out_xfer) begin
            occ_d = occ_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) occ_q <= '0;
        else        occ_q <= occ_d;
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_reg_slice.sv
// Testbench for pipe_reg_slice: directed vector table plus hand-written
// corner sequences on DEPTH=4 instances of both modes, and randomised
// scoreboard runs on DEPTH 1/3/8 in both modes.
module tb_pipe_reg_slice;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, flush, in_valid, out_ready;
    logic [7:0] in_data_c, in_data_s, out_data_c, out_data_s;
    logic       in_ready_c, in_ready_s, out_valid_c, out_valid_s;
    logic [2:0] occ_c;
    logic [3:0] occ_s;

    int n_cmp  = 0;
    int n_fail = 0;
    logic rand_go = 1'b0;

    pipe_reg_slice #(.DATA_WIDTH(8), .DEPTH(4), .SKID_MODE(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .in_valid(in_valid), .in_ready(in_ready_c), .in_data(in_data_c),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c),
        .occupancy(occ_c)
    );

    pipe_reg_slice #(.DATA_WIDTH(8), .DEPTH(4), .SKID_MODE(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data_s),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .occupancy(occ_s)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       fl;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        int         e_occ;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic [7:0] id, input logic ordy,
                                input logic fl, input logic e_ir, input logic e_ov,
                                input logic [7:0] e_od, input int e_occ);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ;
        return v;
    endfunction

    // Randomised scoreboard instances: configs 0..2 comb-ready, 3..5 skid.
    for (genvar g = 0; g < 6; g++) begin : g_rnd
        localparam int D  = (g % 3 == 0) ? 1 : ((g % 3 == 1) ? 3 : 8);
        localparam int S  = g / 3;
        localparam int CW = $clog2(D * (1 + S) + 1);
        logic          iv, ir, ov, ordy;
        logic [7:0]    id, od;
        logic [CW-1:0] occ;
        bit            done = 1'b0;

        pipe_reg_slice #(.DATA_WIDTH(8), .DEPTH(D), .SKID_MODE(S)) u_dut (
            .clk(clk), .rst_n(rst_n), .flush_i(1'b0),
            .in_valid(iv), .in_ready(ir), .in_data(id),
            .out_valid(ov), .out_ready(ordy), .out_data(od),
            .occupancy(occ)
        );

        initial begin
            logic [7:0] q[$];
            int  outs;
            bit  hold, in_x, out_x;
            logic ir_a, ir_b;
            iv = 1'b0; ordy = 1'b0; id = 8'h00;
            outs = 0; hold = 1'b0;
            wait (rand_go);
            for (int cyc = 0; cyc < 20000 && outs < 2000; cyc++) begin
                @(negedge clk);
                if (!hold) begin
                    iv = ($urandom_range(0, 99) < 60);
                    id = 8'($urandom);
                end
                ordy = ($urandom_range(0, 99) < 60);
                #1;
                check($sformatf("rnd%0d occ", g), 32'(occ), 32'(q.size()));
                if (S == 1) begin
                    ir_a = ir;
                    ordy = !ordy;
                    #1;
                    ir_b = ir;
                    ordy = !ordy;
                    #1;
                    check($sformatf("rnd%0d ready_indep", g), 32'(ir_b), 32'(ir_a));
                end
                in_x  = iv && ir;
                out_x = ov && ordy;
                if (out_x) begin
                    if (q.size() > 0) begin
                        check($sformatf("rnd%0d data", g), 32'(od), 32'(q[0]));
                        void'(q.pop_front());
                        outs++;
                    end else begin
                        check($sformatf("rnd%0d underflow", g), 32'(ov), 32'(0));
                    end
                end
                @(posedge clk);
                if (in_x) q.push_back(id);
                hold = iv && !in_x;
            end
            check($sformatf("rnd%0d completed", g), 32'(outs >= 2000), 32'(1));
            done = 1'b1;
        end
    end

    initial begin
        vec_t tbl[$];
        int   occ_b[12] = '{0, 1, 1, 2, 2, 3, 3, 3, 3, 2, 1, 0};
        int   nc, ns, kc, ks;
        logic rc, rs;
        bit   all_done;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data_c = 8'h00; in_data_s = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst in_ready_c", 32'(in_ready_c), 32'(1));
        check("rst in_ready_s", 32'(in_ready_s), 32'(1));
        check("rst out_valid_c", 32'(out_valid_c), 32'(0));
        check("rst out_valid_s", 32'(out_valid_s), 32'(0));
        check("rst occ_c", 32'(occ_c), 32'(0));
        check("rst occ_s", 32'(occ_s), 32'(0));

        // Streaming 01..10 with out_ready=1, then drain.
        for (int c = 0; c <= 20; c++) begin
            int acc, outn;
            acc  = (c < 16) ? c : 16;
            outn = (c > 4) ? c - 4 : 0;
            tbl.push_back(mk(c < 16, 8'(c + 1), 1'b1, 1'b0, 1'b1,
                             (c >= 4 && c <= 19), 8'(c - 3), acc - outn));
        end
        // A0, gap, A1, gap, A2 under backpressure, then release.
        for (int r = 0; r < 12; r++) begin
            logic [7:0] din, dexp;
            din  = (r == 0) ? 8'hA0 : ((r == 2) ? 8'hA1 : 8'hA2);
            dexp = (r <= 8) ? 8'hA0 : ((r == 9) ? 8'hA1 : 8'hA2);
            tbl.push_back(mk(r == 0 || r == 2 || r == 4, din, r >= 8, 1'b0, 1'b1,
                             r >= 4 && r <= 10, dexp, occ_b[r]));
        end
        // Three entries held, then a flush with an FF word offered.
        tbl.push_back(mk(1'b1, 8'hB0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0));
        tbl.push_back(mk(1'b1, 8'hB1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1));
        tbl.push_back(mk(1'b1, 8'hB2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2));
        tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3));
        tbl.push_back(mk(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3));
        tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0));
        tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0));
        tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0));

        foreach (tbl[i]) begin
            @(negedge clk);
            in_valid  = tbl[i].iv;
            in_data_c = tbl[i].id;
            in_data_s = tbl[i].id;
            out_ready = tbl[i].ordy;
            flush     = tbl[i].fl;
            #1;
            check($sformatf("vec%0d in_ready_c", i), 32'(in_ready_c), 32'(tbl[i].e_ir));
            check($sformatf("vec%0d in_ready_s", i), 32'(in_ready_s), 32'(tbl[i].e_ir));
            check($sformatf("vec%0d out_valid_c", i), 32'(out_valid_c), 32'(tbl[i].e_ov));
            check($sformatf("vec%0d out_valid_s", i), 32'(out_valid_s), 32'(tbl[i].e_ov));
            check($sformatf("vec%0d occ_c", i), 32'(occ_c), 32'(tbl[i].e_occ));
            check($sformatf("vec%0d occ_s", i), 32'(occ_s), 32'(tbl[i].e_occ));
            if (tbl[i].e_ov) begin
                check($sformatf("vec%0d out_data_c", i), 32'(out_data_c), 32'(tbl[i].e_od));
                check($sformatf("vec%0d out_data_s", i), 32'(out_data_s), 32'(tbl[i].e_od));
            end
        end

        // Fill under backpressure: 4 accepts comb-ready, 8 accepts skid.
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        nc = 0; ns = 0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            in_data_c = 8'(8'h30 + nc);
            in_data_s = 8'(8'h30 + ns);
            #1;
            rc = in_ready_c;
            rs = in_ready_s;
            @(posedge clk);
            if (rc) nc++;
            if (rs) ns++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("fill accepts_c", 32'(nc), 32'(4));
        check("fill accepts_s", 32'(ns), 32'(8));
        check("fill in_ready_c", 32'(in_ready_c), 32'(0));
        check("fill in_ready_s", 32'(in_ready_s), 32'(0));
        check("fill occ_c", 32'(occ_c), 32'(4));
        check("fill occ_s", 32'(occ_s), 32'(8));
        out_ready = 1'b1;
        kc = 0; ks = 0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid_c) begin
                check($sformatf("drain_c word%0d", kc), 32'(out_data_c), 32'(8'h30 + kc));
                kc++;
            end
            if (out_valid_s) begin
                check($sformatf("drain_s word%0d", ks), 32'(out_data_s), 32'(8'h30 + ks));
                ks++;
            end
            @(negedge clk);
            #1;
        end
        check("drain count_c", 32'(kc), 32'(4));
        check("drain count_s", 32'(ks), 32'(8));
        check("drain occ_c", 32'(occ_c), 32'(0));
        check("drain occ_s", 32'(occ_s), 32'(0));

        // Flush while completely full.
        in_valid = 1'b1; out_ready = 1'b0;
        in_data_c = 8'h55; in_data_s = 8'h55;
        repeat (10) @(negedge clk);
        #1;
        check("full in_ready_c", 32'(in_ready_c), 32'(0));
        check("full in_ready_s", 32'(in_ready_s), 32'(0));
        flush = 1'b1; out_ready = 1'b1;
        #1;
        check("fullflush in_ready_c", 32'(in_ready_c), 32'(0));
        check("fullflush in_ready_s", 32'(in_ready_s), 32'(0));
        check("fullflush out_valid_c", 32'(out_valid_c), 32'(0));
        check("fullflush out_valid_s", 32'(out_valid_s), 32'(0));
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("postflush occ_c", 32'(occ_c), 32'(0));
        check("postflush occ_s", 32'(occ_s), 32'(0));
        check("postflush out_valid_c", 32'(out_valid_c), 32'(0));
        check("postflush out_valid_s", 32'(out_valid_s), 32'(0));

        // Asynchronous reset between edges with three entries held.
        in_valid = 1'b1;
        in_data_c = 8'hC0; in_data_s = 8'hC0;
        @(negedge clk);
        in_data_c = 8'hC1; in_data_s = 8'hC1;
        @(negedge clk);
        in_data_c = 8'hC2; in_data_s = 8'hC2;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("prerst out_valid_c", 32'(out_valid_c), 32'(1));
        check("prerst out_valid_s", 32'(out_valid_s), 32'(1));
        check("prerst occ_c", 32'(occ_c), 32'(3));
        check("prerst occ_s", 32'(occ_s), 32'(3));
        #2;
        rst_n = 1'b0;
        #1;
        check("asyncrst out_valid_c", 32'(out_valid_c), 32'(0));
        check("asyncrst out_valid_s", 32'(out_valid_s), 32'(0));
        check("asyncrst occ_c", 32'(occ_c), 32'(0));
        check("asyncrst occ_s", 32'(occ_s), 32'(0));
        check("asyncrst out_data_c", 32'(out_data_c), 32'(0));
        check("asyncrst out_data_s", 32'(out_data_s), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release in_ready_c", 32'(in_ready_c), 32'(1));
        check("release in_ready_s", 32'(in_ready_s), 32'(1));

        // Randomised runs on the scoreboard instances.
        rand_go = 1'b1;
        fork
            wait (g_rnd[0].done && g_rnd[1].done && g_rnd[2].done &&
                  g_rnd[3].done && g_rnd[4].done && g_rnd[5].done);
            repeat (60000) @(posedge clk);
        join_any
        disable fork;
        all_done = g_rnd[0].done && g_rnd[1].done && g_rnd[2].done &&
                   g_rnd[3].done && g_rnd[4].done && g_rnd[5].done;
        check("random runs finished", 32'(all_done), 32'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_reg_slice.md
Name: pipe_reg_slice

Overview:
- Parametrised elastic register pipeline: DEPTH stages of DATA_WIDTH-bit registers with a valid/ready handshake on both ends.
- Generalises the plain D flip-flop into a stallable, flushable, bubble-collapsing delay line.
- Used wherever a datapath needs registered timing cuts that tolerate downstream backpressure.
- Optional skid mode registers the ready path so long ready chains do not form combinational paths.

Parameters:
DATA_WIDTH, 8, payload width in bits (>=1)
DEPTH, 4, number of pipeline stages (>=1)
SKID_MODE, 0, 0 = ready passes combinationally stage-to-stage; 1 = each stage is a 2-entry skid buffer and in_ready comes from a flop
RESET_DATA, 1, 1 = data registers take RST_VAL on reset; 0 = data registers have no reset (valids always reset)
RST_VAL, '0, reset value of data registers when RESET_DATA=1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
flush_i  input  1  synchronous clear of all held entries
in_valid  input  1  upstream word valid
in_ready  output  1  block can accept a word this cycle
in_data  input  DATA_WIDTH  upstream payload
out_valid  output  1  word available at output
out_ready  input  1  downstream accepts
out_data  output  DATA_WIDTH  output payload; don't-care when out_valid=0
occupancy  output  CNT_W  entries held; CNT_W = $clog2(MAX_OCC+1), MAX_OCC = DEPTH*(1+SKID_MODE)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All stage valids and skid valids clear to 0; occupancy=0; out_valid=0.
  - Data registers take RST_VAL if RESET_DATA=1, otherwise they are unreset.
  - After release, in_ready=1 in both modes.
- Transfers:
  - Input transfer on a clk edge with in_valid && in_ready; output transfer on a clk edge with out_valid && out_ready.
  - in_data must be held stable while in_valid=1 and in_ready=0; no word is dropped or duplicated.
- SKID_MODE=0 stage:
  - ready_up = !v | ready_dn.
  - When ready_up: v <= valid_up; d <= data_up only if valid_up (data enable gated by valid).
  - in_ready is combinational from out_ready through all stages.
- SKID_MODE=1 stage:
  - Holds a main entry and a skid entry; ready_up = !skid_v, driven from a flop.
  - If the main entry is stalled while an upstream word arrives, the word goes to skid.
  - When downstream drains, skid moves to main before a new input is accepted into skid.
  - No combinational in->out ready path.
- Latency and throughput:
  - Empty pipe, out_ready=1: a word accepted at edge N gives out_valid=1 after edge N+DEPTH-1 (DEPTH register stages).
  - Sustained throughput is 1 word/cycle in both modes.
- Bubble collapse: with out_ready=0, later words advance into empty stages until all entries are valid.
  - in_ready=0 exactly when occupancy==MAX_OCC and no output transfer frees a slot in SKID_MODE=0.
  - In SKID_MODE=1, in_ready=0 when the first stage's skid entry is full.
- Ordering: strict FIFO order end to end.
- Occupancy:
  - +1 on input transfer; -1 on output transfer; unchanged when both or neither occur.
  - Always equals the popcount of all valid bits.
  - Never exceeds MAX_OCC or wraps below 0.
- Flush (flush_i=1), with priority over everything except reset:
  - Same cycle: in_ready forced 0 and out_valid forced 0, so no transfers occur.
  - Next edge: all valids clear and occupancy=0. Data registers are unchanged.
  - Flush during full backpressure behaves identically.
- DEPTH=1: single stage in SKID_MODE=0, or one skid buffer in SKID_MODE=1; same rules apply.

Decomposition:
- Package pipe_pkg:
  - typedef enum logic {PIPE_COMB_READY, PIPE_SKID} pipe_mode_e.
  - Function occ_width(depth, mode) returning CNT_W.
- Sub-module pipe_stage (DATA_WIDTH, SKID_MODE, RESET_DATA, RST_VAL): one stage with up/down valid/ready/data plus flush.
- Top level chains DEPTH instances with a generate loop and owns the occupancy counter.

Test Plan:
1. Hold rst_n=0 mid-stream with 3 entries held, between clock edges -> out_valid=0 and occupancy=0 immediately; out_data=8'h00 (RESET_DATA=1, RST_VAL=0); in_ready=1 after release.
2. DEPTH=4, out_ready=1, stream 8'h01..8'h10 back-to-back -> first out_valid the cycle after the 4th edge; outputs 01..10 in order, one per cycle; occupancy steady at 4.
3. out_ready=0 for 12 cycles with in_valid=1 -> in_ready falls after 4 accepts (SKID_MODE=0) or 8 accepts (SKID_MODE=1); occupancy=4/8; on release, all words emerge once each, in order.
4. Inputs 8'hA0, gap, 8'hA1, gap, 8'hA2 with out_ready=0 -> entries compact into adjacent stages; occupancy=3; in_ready stays 1.
5. Occupancy=3 and flush_i=1 for one cycle with in_valid=1, in_data=8'hFF, out_ready=1 -> that cycle in_ready=0 and out_valid=0; next cycle occupancy=0; 8'hFF is never output.
6. 2000 transactions with random in_valid/out_ready, both modes, DEPTH in {1,3,8} -> scoreboard order match, occupancy equals model count, and in_ready has no combinational dependence on out_ready when SKID_MODE=1.
